// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its downstream scanner.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_d;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam int SCAN_CNT_W = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_DIVIDE = 3'd3,
    S_OUTPUT = 3'd4,
    S_DONE   = 3'd5
  } scan_state_t;

  function automatic operand_d sext(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/instr_serial_div.sv
// Serial restoring divider on operand magnitudes with signed fix-up of the results.
// The first iteration is folded into the load edge so that done is visible exactly
// DIV_STEPS cycles after start.
module instr_serial_div
  import instr_register_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  input  logic     start_i,
  input  operand_t a_i,
  input  operand_t b_i,
  output logic     busy_o,
  output logic     done_o,
  output operand_d quot_o,
  output operand_d rem_o
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] first_step;
  logic [63:0] next_step;
  logic [63:0] quo_ext;
  logic [63:0] rem_ext;

  // One shift-subtract iteration: returns {remainder, quotient_shift_register}.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] sh;
    logic [32:0] trial;
    sh    = {r, q[31]};
    trial = sh - {1'b0, d};
    if (!trial[32]) return {trial[31:0], q[30:0], 1'b1};
    return {sh[31:0], q[30:0], 1'b0};
  endfunction

  // Magnitudes and iteration results; -2^31 maps to 0x8000_0000 unsigned.
  always_comb begin
    mag_a      = a_i[31] ? (~a_i + 32'd1) : a_i;
    mag_b      = b_i[31] ? (~b_i + 32'd1) : b_i;
    first_step = div_step(32'd0, mag_a, mag_b);
    next_step  = div_step(rem_q, quo_q, div_q);
    quo_ext    = {32'd0, quo_q};
    rem_ext    = {32'd0, rem_q};
  end

  // Iteration state: load on start, step while busy, pulse done after the last step.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        {rem_q, quo_q} <= first_step;
        div_q          <= mag_b;
        neg_quo_q      <= a_i[31] ^ b_i[31];
        neg_rem_q      <= a_i[31];
        cnt_q          <= 6'(DIV_STEPS - 1);
        if (DIV_STEPS > 1) busy_q <= 1'b1;
        else               done_q <= 1'b1;
      end else if (busy_q) begin
        {rem_q, quo_q} <= next_step;
        cnt_q          <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = neg_quo_q ? operand_d'(-quo_ext) : operand_d'(quo_ext);
  assign rem_o  = neg_rem_q ? operand_d'(-rem_ext) : operand_d'(rem_ext);

endmodule

// File: rtl/instr_exec_scanner.sv
// Walks a range of instruction register slots, executes each instruction and streams
// the results out on a valid/ready port.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for start
//  S_FETCH  | instruction_word at read_pointer captured at the edge
//  S_EXEC   | one-cycle ALU result, or divider launch for DIV/MOD
//  S_DIVIDE | waiting for the serial divider
//  S_OUTPUT | res_valid held until res_ready
//  S_DONE   | done pulse, then back to idle
module instr_exec_scanner
  import instr_register_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4:0]            base_ptr,
  input  logic [SCAN_CNT_W-1:0] count,
  output logic [4:0]            read_pointer,
  input  instruction_t          instruction_word,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4:0]            res_ptr,
  output opcode_t               res_opc,
  output logic signed [63:0]    res_value,
  output logic                  res_dz
);

  scan_state_t           state_q;
  address_t              rp_q;
  logic [SCAN_CNT_W-1:0] remaining_q;
  opcode_t               opc_q;
  operand_t              op_a_q;
  operand_t              op_b_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  res_valid_q;
  address_t              res_ptr_q;
  opcode_t               res_opc_q;
  operand_d              res_value_q;
  logic                  res_dz_q;

  operand_d              alu_d;
  logic                  is_div_op;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  operand_d              div_quot;
  operand_d              div_rem;

  // Single-cycle ALU; operands widen to 64 bits first so ADD/SUB/MULT cannot overflow.
  always_comb begin
    alu_d = '0;
    case (opc_q)
      ZERO:    alu_d = '0;
      PASSA:   alu_d = sext(op_a_q);
      PASSB:   alu_d = sext(op_b_q);
      ADD:     alu_d = sext(op_a_q) + sext(op_b_q);
      SUB:     alu_d = sext(op_a_q) - sext(op_b_q);
      MULT:    alu_d = sext(op_a_q) * sext(op_b_q);
      default: alu_d = '0;
    endcase
  end

  assign is_div_op = (opc_q == DIV) || (opc_q == MOD);
  assign div_start = (state_q == S_EXEC) && is_div_op && (op_b_q != '0) && !div_busy;

  instr_serial_div #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (div_start),
    .a_i       (op_a_q),
    .b_i       (op_b_q),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  // Scan FSM with pointer/remaining counters and the registered result port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rp_q        <= '0;
      remaining_q <= '0;
      opc_q       <= ZERO;
      op_a_q      <= '0;
      op_b_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ptr_q   <= '0;
      res_opc_q   <= ZERO;
      res_value_q <= '0;
      res_dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              rp_q        <= base_ptr;
              remaining_q <= count;
              busy_q      <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          opc_q   <= instruction_word.opc;
          op_a_q  <= instruction_word.op_a;
          op_b_q  <= instruction_word.op_b;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_div_op && (op_b_q != '0)) begin
            state_q <= S_DIVIDE;
          end else begin
            // Division by zero short-circuits with a zero result and the dz flag.
            res_value_q <= is_div_op ? '0 : alu_d;
            res_dz_q    <= is_div_op;
            res_ptr_q   <= rp_q;
            res_opc_q   <= opc_q;
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end
        end
        S_DIVIDE: begin
          if (div_done) begin
            res_value_q <= (opc_q == DIV) ? div_quot : div_rem;
            res_dz_q    <= 1'b0;
            res_ptr_q   <= rp_q;
            res_opc_q   <= opc_q;
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            remaining_q <= remaining_q - 1'b1;
            rp_q        <= rp_q + 5'd1;
            if (remaining_q == 1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_pointer = rp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign res_valid    = res_valid_q;
  assign res_ptr      = res_ptr_q;
  assign res_opc      = res_opc_q;
  assign res_value    = res_value_q;
  assign res_dz       = res_dz_q;

endmodule

// File: tb/tb_instr_exec_scanner.sv
// Bench for instr_exec_scanner: register-file model, result scoreboard and directed scans.
module tb_instr_exec_scanner;
  import instr_register_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [4:0]         base_ptr = '0;
  logic [5:0]         count = '0;
  logic [4:0]         read_pointer;
  instruction_t       instruction_word;
  logic               busy;
  logic               done;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [4:0]         res_ptr;
  opcode_t            res_opc;
  logic signed [63:0] res_value;
  logic               res_dz;

  instruction_t regs [32];
  assign instruction_word = regs[read_pointer];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] ptr;
    opcode_t    opc;
    longint     val;
    bit         dz;
  } exp_t;

  exp_t exp_q[$];
  bit   hs_last = 0;
  bit   zero_flag = 0;
  bit   stall_prev = 0;
  logic [4:0]         p_ptr;
  opcode_t            p_opc;
  logic signed [63:0] p_val;
  logic               p_dz;

  always #5 clk = ~clk;

  instr_exec_scanner dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .base_ptr         (base_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .done             (done),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_ptr          (res_ptr),
    .res_opc          (res_opc),
    .res_value        (res_value),
    .res_dz           (res_dz)
  );

  // Reference semantics in plain 64-bit integer arithmetic.
  function automatic longint model_eval(input instruction_t ins, output bit dz);
    longint a;
    longint b;
    a  = longint'(ins.op_a);
    b  = longint'(ins.op_b);
    dz = 0;
    case (ins.opc)
      ZERO:  return 0;
      PASSA: return a;
      PASSB: return b;
      ADD:   return a + b;
      SUB:   return a - b;
      MULT:  return a * b;
      DIV:   if (b == 0) begin dz = 1; return 0; end else return a / b;
      default: if (b == 0) begin dz = 1; return 0; end else return a % b;
    endcase
  endfunction

  function automatic bit is_slow(input instruction_t ins);
    return (ins.opc == DIV || ins.opc == MOD) && ins.op_b != 0;
  endfunction

  task automatic check(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Scoreboard: every handshake, done timing and stall stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      hs_last    = 0;
      zero_flag  = 0;
      stall_prev = 0;
    end else begin
      checks++;
      if (done !== (hs_last || zero_flag)) begin
        errors++;
        $display("FAIL done_pulse: got %b want %b", done, hs_last || zero_flag);
      end
      hs_last   = 0;
      zero_flag = 0;
      if (stall_prev) begin
        checks++;
        if (res_valid !== 1'b1 || res_ptr !== p_ptr || res_opc !== p_opc ||
            res_value !== p_val || res_dz !== p_dz) begin
          errors++;
          $display("FAIL hold: got v=%b ptr=%0d val=%0d want v=1 ptr=%0d val=%0d",
                   res_valid, res_ptr, res_value, p_ptr, p_val);
        end
      end
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got ptr=%0d val=%0d want none", res_ptr, res_value);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (res_ptr !== e.ptr || res_opc !== e.opc || res_value !== e.val || res_dz !== e.dz) begin
            errors++;
            $display("FAIL result: got ptr=%0d opc=%0d val=%0d dz=%b want ptr=%0d opc=%0d val=%0d dz=%b",
                     res_ptr, res_opc, res_value, res_dz, e.ptr, e.opc, e.val, e.dz);
          end
          if (exp_q.size() == 0) hs_last = 1;
        end
      end
      stall_prev = res_valid && !res_ready;
      p_ptr = res_ptr;
      p_opc = res_opc;
      p_val = res_value;
      p_dz  = res_dz;
    end
  end

  task automatic push_scan(input logic [4:0] b, input int c);
    for (int i = 0; i < c; i++) begin
      exp_t e;
      bit   dz;
      e.ptr = 5'((int'(b) + i) % 32);
      e.opc = regs[e.ptr].opc;
      e.val = model_eval(regs[e.ptr], dz);
      e.dz  = dz;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_scan(input string name, input logic [4:0] b, input int c,
                         input int lat_exp, input longint first_exp, input bit dz_exp);
    int lat;
    int n;
    push_scan(b, c);
    start    = 1'b1;
    base_ptr = b;
    count    = 6'(c);
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, lat_exp);
    check({name, "_first_value"}, res_value, first_exp);
    check({name, "_first_dz"}, longint'(res_dz), longint'(dz_exp));
    check({name, "_first_ptr"}, longint'(res_ptr), longint'(b));
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, longint'(done), 1);
    check({name, "_ptr_after"}, longint'(read_pointer), longint'((int'(b) + c) % 32));
    @(posedge clk); #1;
    check({name, "_idle_busy"}, longint'(busy), 0);
  endtask

  task automatic do_zero();
    start    = 1'b1;
    base_ptr = 5'd9;
    count    = 6'd0;
    @(posedge clk); #1;
    start     = 1'b0;
    zero_flag = 1;
    check("zero_done", longint'(done), 1);
    check("zero_valid", longint'(res_valid), 0);
    @(posedge clk); #1;
    check("zero_done_clear", longint'(done), 0);
  endtask

  initial begin
    int n;
    bit dz;
    longint fv;
    for (int i = 0; i < 32; i++) regs[i] = '{opc: ZERO, op_a: 32'sd0, op_b: 32'sd0};

    #12;
    check("rst_read_pointer", longint'(read_pointer), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_valid", longint'(res_valid), 0);
    check("rst_value", res_value, 0);
    check("rst_opc", longint'(res_opc), longint'(ZERO));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    regs[3] = '{opc: ADD, op_a: -32'sd5, op_b: 32'sd7};
    do_scan("add", 5'd3, 1, 3, 2, 0);

    regs[31] = '{opc: MULT, op_a: -32'sd15, op_b: 32'sd15};
    regs[0]  = '{opc: SUB,  op_a: 32'sd4,   op_b: 32'sd9};
    do_scan("wrap", 5'd31, 2, 3, -225, 0);

    regs[5] = '{opc: DIV, op_a: -32'sd7, op_b: 32'sd2};
    regs[6] = '{opc: MOD, op_a: -32'sd7, op_b: 32'sd2};
    do_scan("divmod", 5'd5, 2, 35, -3, 0);

    regs[8] = '{opc: DIV, op_a: 32'sh8000_0000, op_b: -32'sd1};
    do_scan("div_min", 5'd8, 1, 35, 64'sd2147483648, 0);

    regs[9] = '{opc: ADD, op_a: 32'sh7fff_ffff, op_b: 32'sh7fff_ffff};
    do_scan("add_wide", 5'd9, 1, 3, 64'sd4294967294, 0);

    regs[7]  = '{opc: DIV, op_a: 32'sd9, op_b: 32'sd0};
    regs[10] = '{opc: MOD, op_a: 32'sd9, op_b: 32'sd0};
    do_scan("div_zero", 5'd7, 1, 3, 0, 1);
    do_scan("mod_zero", 5'd10, 1, 3, 0, 1);

    regs[11] = '{opc: MOD, op_a: 32'sd7, op_b: -32'sd2};
    do_scan("mod_neg_b", 5'd11, 1, 35, 1, 0);

    // Back-pressure with an ignored start pulse in the middle.
    regs[12] = '{opc: ADD,   op_a: 32'sd100, op_b: -32'sd1};
    regs[13] = '{opc: PASSB, op_a: 32'sd0,   op_b: -32'sd42};
    res_ready = 1'b0;
    push_scan(5'd12, 2);
    start = 1'b1; base_ptr = 5'd12; count = 6'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("stall_first_value", res_value, 99);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin start = 1'b1; base_ptr = 5'd0; count = 6'd3; end
      else start = 1'b0;
      @(posedge clk); #1;
      check("stall_read_pointer", longint'(read_pointer), 12);
      check("stall_valid", longint'(res_valid), 1);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    check("stall_done_seen", longint'(done), 1);
    check("stall_ptr_after", longint'(read_pointer), 14);
    @(posedge clk); #1;

    // Reset in the middle of a division.
    start = 1'b1; base_ptr = 5'd5; count = 6'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("mid_div_busy", longint'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("arst_read_pointer", longint'(read_pointer), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_valid", longint'(res_valid), 0);
    check("arst_res_ptr", longint'(res_ptr), 0);
    check("arst_res_opc", longint'(res_opc), longint'(ZERO));
    check("arst_res_value", res_value, 0);
    check("arst_res_dz", longint'(res_dz), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_zero();
    do_scan("after_reset", 5'd5, 2, 35, -3, 0);

    // Full-wrap scan over pseudo-random contents.
    for (int i = 0; i < 32; i++) begin
      regs[i].opc  = opcode_t'($urandom_range(0, 7));
      regs[i].op_a = operand_t'($urandom);
      regs[i].op_b = ($urandom_range(0, 5) == 0) ? 32'sd0 : operand_t'($urandom);
    end
    fv = model_eval(regs[17], dz);
    do_scan("full_wrap", 5'd17, 32, is_slow(regs[17]) ? 35 : 3, fv, dz);
    check("full_wrap_drained", longint'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
